// File: rtl/spi_ram_burst_slave.sv
// rtl/spi_ram_burst_slave.sv - SPI slave giving burst read/write access to an internal RAM
// Two command bits pick address/data and read/write; data commands stream words until SS_n rises.
module spi_ram_burst_slave #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy,
   output logic err
);
   localparam int SH_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(SH_W + 1);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_WR_ADDR, S_RD_ADDR, S_WR_DATA, S_RD_DATA
   } state_t;

   state_t                 state_q, state_d;
   logic                   cmd_hi_q, cmd_hi_d;
   logic [SH_W-1:0]        shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   word_done_q, word_done_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
   logic                   miso_q, miso_d;
   logic                   err_q, err_d;

   logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0]  mem_q;
   logic                   rd_oor_q;

   logic [SH_W-1:0]        shift_in;
   logic [DATA_WIDTH-1:0]  rd_word;
   logic [ADDR_WIDTH-1:0]  rd_port_addr;
   logic                   rd_in_range;
   logic                   wr_in_range;
   logic                   last_addr_bit;
   logic                   last_data_bit;
   logic                   mem_we;

   function automatic logic [ADDR_WIDTH-1:0] addr_incr(input logic [ADDR_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

   assign shift_in      = {shift_q[SH_W-2:0], MOSI};
   assign last_addr_bit = (cnt_q == CNT_W'(ADDR_WIDTH - 1));
   assign last_data_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));
   assign rd_word       = rd_oor_q ? '0 : mem_q;
   assign wr_in_range   = (32'(wr_addr_q) < MEM_DEPTH);
   assign rd_in_range   = (32'(rd_port_addr) < MEM_DEPTH);

   // Prefetch the next word while streaming so each reload lands on the word boundary edge.
   assign rd_port_addr  = (state_q == S_CMD || state_q == S_RD_DATA) ? addr_incr(rd_addr_q)
                                                                     : rd_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (SS_n) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_CMD;
            S_CMD: begin
               case ({cmd_hi_q, MOSI})
                  2'b00:   state_d = S_WR_ADDR;
                  2'b10:   state_d = S_RD_ADDR;
                  2'b01:   state_d = S_WR_DATA;
                  default: state_d = S_RD_DATA;
               endcase
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      cmd_hi_d    = cmd_hi_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      word_done_d = word_done_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      miso_d      = 1'b0;
      err_d       = 1'b0;
      mem_we      = 1'b0;
      busy        = (state_q != S_IDLE);
      if (SS_n) begin
         shift_d     = '0;
         cnt_d       = '0;
         word_done_d = 1'b0;
         err_d       = (state_q != S_IDLE) && !word_done_q;
      end else begin
         case (state_q)
            S_IDLE: cmd_hi_d = MOSI;
            S_CMD: begin
               cnt_d   = '0;
               shift_d = (cmd_hi_q && MOSI) ? SH_W'(rd_word) : '0;
            end
            S_WR_ADDR, S_RD_ADDR: begin
               if (!word_done_q) begin
                  shift_d = shift_in;
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (last_addr_bit) begin
                     word_done_d = 1'b1;
                     if (state_q == S_WR_ADDR) begin
                        wr_addr_d = shift_in[ADDR_WIDTH-1:0];
                     end else begin
                        rd_addr_d = shift_in[ADDR_WIDTH-1:0];
                     end
                  end
               end
            end
            S_WR_DATA: begin
               shift_d = shift_in;
               cnt_d   = cnt_q + CNT_W'(1);
               if (last_data_bit) begin
                  cnt_d       = '0;
                  word_done_d = 1'b1;
                  mem_we      = wr_in_range;
                  wr_addr_d   = addr_incr(wr_addr_q);
               end
            end
            S_RD_DATA: begin
               miso_d  = shift_q[DATA_WIDTH-1];
               shift_d = {shift_q[SH_W-2:0], 1'b0};
               cnt_d   = cnt_q + CNT_W'(1);
               if (last_data_bit) begin
                  cnt_d       = '0;
                  word_done_d = 1'b1;
                  shift_d     = SH_W'(rd_word);
                  rd_addr_d   = addr_incr(rd_addr_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_hi_q    <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         word_done_q <= 1'b0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         miso_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cmd_hi_q    <= cmd_hi_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         word_done_q <= word_done_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         miso_q      <= miso_d;
         err_q       <= err_d;
      end
   end

   // RAM keeps its contents through reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_addr_q[IDX_W-1:0]] <= shift_in[DATA_WIDTH-1:0];
      end
      if (rd_in_range) begin
         mem_q <= mem[rd_port_addr[IDX_W-1:0]];
      end
      rd_oor_q <= !rd_in_range;
   end

   assign MISO = miso_q;
   assign err  = err_q;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb/tb_spi_ram_burst_slave.sv - self-checking bench for spi_ram_burst_slave
// Two instances (depth 256 and 200) see identical frames; a frame-level model predicts both.
module tb_spi_ram_burst_slave;
   localparam int D0 = 256;
   localparam int D1 = 200;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ss_n = 1'b1;
   logic mosi = 1'b0;
   logic miso0, busy0, err0, miso1, busy1, err1;

   always #5 clk = ~clk;

   spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(D0)) dut0 (
      .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
      .MISO(miso0), .busy(busy0), .err(err0)
   );

   spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(D1)) dut1 (
      .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
      .MISO(miso1), .busy(busy1), .err(err1)
   );

   logic [7:0]  mmem  [2][256];
   bit          known [2][256];
   logic [7:0]  m_wr  [2];
   logic [7:0]  m_rd  [2];
   bit          exp_busy, exp_err;
   bit          exp_miso [2];
   bit          exp_mchk [2];
   logic [31:0] cap [2];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          run = 1'b0;

   function automatic int depth_of(input int d);
      return (d == 0) ? D0 : D1;
   endfunction

   function automatic logic [7:0] next_addr(input int d, input logic [7:0] a);
      return (int'(a) == depth_of(d) - 1) ? 8'd0 : a + 8'd1;
   endfunction

   function automatic logic get_miso(input int d);
      return (d == 0) ? miso0 : miso1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic capture();
      for (int d = 0; d < 2; d++) cap[d] = {cap[d][30:0], get_miso(d)};
   endtask

   task automatic set_quiet(input bit e);
      exp_busy = 1'b0;
      exp_err  = e;
      for (int d = 0; d < 2; d++) begin
         exp_miso[d] = 1'b0;
         exp_mchk[d] = 1'b1;
      end
   endtask

   // Per-cycle compare of all outputs against the model expectations.
   initial begin
      wait (run);
      forever begin
         @(posedge clk);
         #2;
         check("busy0", busy0, exp_busy);
         check("busy1", busy1, exp_busy);
         check("err0", err0, exp_err);
         check("err1", err1, exp_err);
         if (exp_mchk[0]) check("miso0", miso0, exp_miso[0]);
         if (exp_mchk[1]) check("miso1", miso1, exp_miso[1]);
      end
   end

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         ss_n = 1'b1;
         mosi = 1'b0;
         set_quiet(1'b0);
      end
   endtask

   // Drives cmd + npl payload bits (pl bit npl-1 first); abort_rst replaces the SS_n rise with a reset.
   task automatic frame(input logic [1:0] cmd, input int npl, input logic [31:0] pl,
                        input bit abort_rst = 1'b0);
      int         nbits;
      bit         trunc;
      logic [7:0] w;
      nbits  = 2 + npl;
      cap[0] = '0;
      cap[1] = '0;
      for (int j = 0; j < nbits; j++) begin
         int         i;
         logic [7:0] a;
         @(negedge clk);
         if (j >= 3) capture();
         ss_n     = 1'b0;
         mosi     = (j < 2) ? cmd[1 - j] : pl[npl - 1 - (j - 2)];
         exp_busy = 1'b1;
         exp_err  = 1'b0;
         for (int d = 0; d < 2; d++) begin
            exp_miso[d] = 1'b0;
            exp_mchk[d] = 1'b1;
            if (cmd == 2'b11 && j >= 2) begin
               i = j - 2;
               a = m_rd[d];
               for (int k = 0; k < i / 8; k++) a = next_addr(d, a);
               if (int'(a) >= depth_of(d)) exp_miso[d] = 1'b0;
               else if (!known[d][a]) exp_mchk[d] = 1'b0;
               else exp_miso[d] = mmem[d][a][7 - (i % 8)];
            end
         end
      end
      @(negedge clk);
      if (nbits >= 3) capture();
      if (abort_rst) begin
         rst = 1'b1;
         set_quiet(1'b0);
         #1;
         check("rst_busy0", busy0, 0);
         check("rst_miso0", miso0, 0);
         check("rst_busy1", busy1, 0);
         check("rst_miso1", miso1, 0);
         @(negedge clk);
         rst  = 1'b0;
         ss_n = 1'b1;
         mosi = 1'b0;
         set_quiet(1'b0);
         for (int d = 0; d < 2; d++) begin
            m_wr[d] = 8'd0;
            m_rd[d] = 8'd0;
         end
         return;
      end
      ss_n  = 1'b1;
      mosi  = 1'b0;
      trunc = (npl < 8);
      set_quiet(trunc);
      for (int d = 0; d < 2; d++) begin
         case (cmd)
            2'b00: if (!trunc) m_wr[d] = pl[npl - 1 -: 8];
            2'b10: if (!trunc) m_rd[d] = pl[npl - 1 -: 8];
            2'b01: begin
               for (int k = 0; k < npl / 8; k++) begin
                  w = pl[npl - 1 - 8 * k -: 8];
                  if (int'(m_wr[d]) < depth_of(d)) begin
                     mmem[d][m_wr[d]]  = w;
                     known[d][m_wr[d]] = 1'b1;
                  end
                  m_wr[d] = next_addr(d, m_wr[d]);
               end
            end
            default: for (int k = 0; k < npl / 8; k++) m_rd[d] = next_addr(d, m_rd[d]);
         endcase
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] addr, data;
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 256; a++) known[d][a] = 1'b0;
         m_wr[d] = 8'd0;
         m_rd[d] = 8'd0;
         cap[d]  = '0;
      end
      set_quiet(1'b0);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      run = 1'b1;
      check("reset_busy", busy0, 0);
      check("reset_miso", miso0, 0);
      check("reset_err", err0, 0);
      check("reset_wr_addr", dut0.wr_addr_q, 0);
      check("reset_rd_addr", dut0.rd_addr_q, 0);
      check("reset_shift", dut0.shift_q, 0);
      rst = 1'b0;
      idle(2);

      // Single word write then read back at 0x64.
      frame(2'b00, 8, 32'h64);
      frame(2'b01, 8, 32'h0B);
      frame(2'b10, 8, 32'h64);
      frame(2'b11, 8, 32'h0);
      check("basic_read0", cap[0], 32'h0B);
      check("basic_read1", cap[1], 32'h0B);

      // Burst write across the top of memory.
      frame(2'b00, 8, 32'hFE);
      frame(2'b01, 24, 32'hA1A2A3);
      check("wrap_mem254", dut0.mem[254], 8'hA1);
      check("wrap_mem255", dut0.mem[255], 8'hA2);
      check("wrap_mem0", dut0.mem[0], 8'hA3);
      check("wrap_wr_addr0", dut0.wr_addr_q, 1);
      check("oor_mem0_d1", dut1.mem[0], 8'hA3);
      check("oor_wr_addr1", dut1.wr_addr_q, 1);

      // Gapless burst read.
      frame(2'b10, 8, 32'hFE);
      frame(2'b11, 24, 32'h0);
      check("burst_read0", cap[0], 32'hA1A2A3);
      check("burst_read1", cap[1], 32'h0000A3);
      check("burst_rd_addr0", dut0.rd_addr_q, 1);

      // Truncated frames raise err and leave state alone.
      frame(2'b00, 8, 32'h01);
      frame(2'b01, 8, 32'h3C);
      frame(2'b00, 8, 32'h01);
      frame(2'b01, 3, 32'h5);
      @(posedge clk);
      #1 check("trunc_err_hi", err0, 1);
      idle(1);
      @(posedge clk);
      #1 check("trunc_err_lo", err0, 0);
      check("trunc_mem1", dut0.mem[1], 8'h3C);
      check("trunc_wr_addr", dut0.wr_addr_q, 1);
      frame(2'b00, 4, 32'hF);
      frame(2'b11, 0, 32'h0);
      check("trunc_addr_wr_addr", dut0.wr_addr_q, 1);

      // Partial trailing words are discarded silently.
      frame(2'b01, 13, {19'd0, 8'h5A, 5'h1F});
      check("partial_wr_mem1", dut0.mem[1], 8'h5A);
      check("partial_wr_addr", dut0.wr_addr_q, 2);
      frame(2'b10, 8, 32'h01);
      frame(2'b11, 12, 32'h0);
      check("partial_rd", cap[0][11:4], 8'h5A);
      check("partial_rd_addr", dut0.rd_addr_q, 2);

      // Reset in the middle of a write-data frame.
      frame(2'b00, 8, 32'd50);
      frame(2'b01, 8, 32'h77);
      frame(2'b00, 8, 32'd50);
      frame(2'b01, 3, 32'h6, 1'b1);
      check("abort_mem50_d0", dut0.mem[50], 8'h77);
      check("abort_mem50_d1", dut1.mem[50], 8'h77);
      check("abort_wr_addr", dut0.wr_addr_q, 0);
      for (int p = 0; p < 100; p++) begin
         addr = 8'(100 + p);
         data = 8'(11 * ((p % 23) + 1));
         frame(2'b00, 8, {24'd0, addr});
         frame(2'b01, 8, {24'd0, data});
         frame(2'b10, 8, {24'd0, addr});
         frame(2'b11, 8, 32'h0);
         check("pair_rd0", cap[0], {24'd0, data});
         check("pair_rd1", cap[1], {24'd0, data});
      end

      // Out-of-range access on the depth-200 instance.
      frame(2'b00, 8, 32'd210);
      frame(2'b01, 8, 32'h55);
      frame(2'b10, 8, 32'd210);
      frame(2'b11, 8, 32'h0);
      check("oor_rd0", cap[0], 32'h55);
      check("oor_rd1", cap[1], 32'h0);
      for (int a = 0; a < D1; a++) begin
         if (known[1][a]) check("oor_mem_keep", dut1.mem[a], mmem[1][a]);
      end

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_ram_burst_slave.md
SPI_RAM_BURST_SLAVE -- requirements
Module: spi_ram_burst_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: address payload width in bits.
REQ-002 Parameter DATA_WIDTH, default 8: data word and payload width in bits.
REQ-003 Parameter MEM_DEPTH, default 256: number of words, 1..2**ADDR_WIDTH.
REQ-004 clk  in  1: single clock; all sampling and updates occur on the rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 SS_n  in  1: active-low slave select; one frame spans one low period.
REQ-007 MOSI  in  1: serial command and payload from master, MSB first.
REQ-008 MISO  out  1: serial read data to master, MSB first, registered.
REQ-009 busy  out  1: high while a frame is in progress (state not IDLE).
REQ-010 err  out  1: one-cycle pulse flagging a truncated frame.

Function
REQ-011 Frame timing: edge k is the first edge with SS_n sampled low; MOSI at edge k is cmd[1], at k+1 is cmd[0], and at k+2+i is payload bit i, MSB first.
REQ-012 cmd 00 = write address: after ADDR_WIDTH payload bits (edge k+1+ADDR_WIDTH), wr_addr SHALL load the payload; any further bits SHALL be ignored until SS_n rises.
REQ-013 cmd 10 = read address: same timing as REQ-012, loading rd_addr.
REQ-014 cmd 01 = write data: at edge k+1+DATA_WIDTH*(n+1), word n SHALL be written to mem[wr_addr], then wr_addr SHALL increment.
REQ-015 Burst write: while SS_n stays low, every further DATA_WIDTH bits form the next word, with no limit on word count.
REQ-016 cmd 11 = read data: at edge k+1 the shift register SHALL load mem[rd_addr]; MISO SHALL present bit DATA_WIDTH-1-i of word n from edge k+2+DATA_WIDTH*n+i.
REQ-017 Burst read: at edge k+1+DATA_WIDTH*(n+1), rd_addr SHALL increment and the shift register SHALL reload from the new rd_addr, giving a gapless bit stream.
REQ-018 Address increment SHALL wrap from MEM_DEPTH-1 to 0.
REQ-019 Out-of-range address (>= MEM_DEPTH): writes SHALL be dropped and reads SHALL return 0; the address still increments and wraps modulo 2**ADDR_WIDTH, then per REQ-018 once in range.
REQ-020 States: IDLE -> CMD (SS_n sampled low) -> WR_ADDR | RD_ADDR | WR_DATA | RD_DATA (cmd[0] sampled at k+1) -> IDLE (SS_n sampled high).
REQ-021 Any edge with SS_n sampled high SHALL return the block to IDLE, discard any partial word, and drive MISO 0 from that edge.
REQ-022 err SHALL pulse for one cycle when SS_n rises before the first payload word of a frame completes (fewer than 2+payload-width bits).
REQ-023 A partial burst word after at least one complete word SHALL be discarded silently, with no err.
REQ-024 MISO SHALL be 0 in every state except RD_DATA.
REQ-025 The block SHALL accept back-to-back frames separated by one clk of SS_n high.
REQ-026 Memory SHALL be inferable block RAM: one synchronous write port and one synchronous read port.

Reset
REQ-027 rst high SHALL immediately force state IDLE, MISO 0, busy 0, err 0, wr_addr 0, rd_addr 0, and a cleared shift register.
REQ-028 Memory contents SHALL NOT be affected by reset.
REQ-029 Reset mid-frame SHALL abort the frame with no memory write; the first frame after rst falls SHALL behave normally.

Verification
REQ-030 Frame 00 + 0x64, frame 01 + 0x0B, frame 10 + 0x64, frame 11 -> MISO outputs 0,0,0,0,1,0,1,1 starting at edge k+2.
REQ-031 Frame 00 + 0xFE, then one frame 01 + 0xA1,0xA2,0xA3 -> mem[254]=A1, mem[255]=A2, mem[0]=A3, wr_addr=1.
REQ-032 Frame 10 + 0xFE, then frame 11 held for 24 bits -> MISO streams A1 A2 A3 with no gap bits.
REQ-033 Frame 01 with SS_n raised after cmd + 3 bits -> err high exactly one cycle, memory unchanged, wr_addr unchanged.
REQ-034 rst asserted 5 bits into a write-data frame -> busy 0 and MISO 0 immediately, target word unchanged, the next 100 write/read pairs at addresses 100..199 with data 11,22,...,253 (then wrapping to 11) read back correctly.
REQ-035 MEM_DEPTH=200: write 0x55 to address 210, then read address 210 -> MISO all zeros, mem[0..199] unchanged.
